mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between EX and WB in the five-stage CPU. Latches the EX result bus under the common stall protocol, extracts and extends load data from the data SRAM, and emits the packed bus consumed by WB. A one-entry hold buffer keeps load data intact while the stage is frozen. The stage also drives same-cycle forwarding buses to ID, for both the GPR write and the HI/LO write.

## Interface
- Parameters: none. Widths come from `lib/defines.vh`: `StallBus`=6, `Stop`=1'b1, `NoStop`=1'b0, `EX_TO_MEM_WD`=79, `MEM_TO_WB_WD`=70.
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- stall  in  `StallBus`  pipeline freeze vector; bit 3 = EX/MEM register, bit 4 = MEM/WB register.
- ex_to_mem_bus  in  79  {pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0], load_type[2:0]}, MSB first.
- ex_to_mem1  in  66  {hi_we, lo_we, hi[31:0], lo[31:0]}.
- data_sram_rdata  in  32  SRAM read data; valid the cycle after EX issued the request.
- mem_to_wb_bus  out  70  {pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- mem_to_wb1  out  66  registered copy of ex_to_mem1.
- mem_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata}, GPR forwarding to ID.
- mem_to_id_2  out  66  identical to mem_to_wb1, HI/LO forwarding to ID.

## Operation
**Pipeline register.** Bus register plus HI/LO register. Priority order, evaluated each posedge:
1. rst: clear both registers to 0.
2. else if stall[3]==Stop and stall[4]==NoStop: clear both (inject a bubble).
3. else if stall[3]==NoStop: load ex_to_mem_bus and ex_to_mem1.
4. else: hold.

**Hold buffer.** State machine with states EMPTY and HELD, plus a 32-bit hold_data register.
- EMPTY → HELD: stage holds a load (data_ram_en=1, data_ram_wen=0, sel_rf_res=1), stall[3]==Stop and stall[4]==Stop. Capture data_sram_rdata into hold_data.
- HELD → EMPTY: on any posedge where rule 1, 2 or 3 fires.
- HELD, rule 4: keep hold_data; ignore data_sram_rdata.
- raw_data = HELD ? hold_data : data_sram_rdata.

**Load extraction.** addr = ex_result[1:0]; little-endian, byte k = raw_data[8k+7:8k].
- load_type 000: word, raw_data.
- 001 lb: byte[addr], sign-extended.
- 010 lbu: byte[addr], zero-extended.
- 011 lh: addr[1]?raw[31:16]:raw[15:0], sign-extended.
- 100 lhu: same halfword select, zero-extended.
- 101–111: treated as word.
- Misalignment is not checked; addr[0] is ignored for halfword loads.

**Result.** rf_wdata = sel_rf_res ? load_data : ex_result. pc, rf_we and rf_waddr pass through from the register. Stores have rf_we=0 from EX; the stage does not modify it.

## Timing
- All outputs are combinational from the registered state and data_sram_rdata; no added latency. An instruction latched at edge N is presented to WB at edge N+1, unless WB is stalled.
- Reset values: every output is 0, FSM is EMPTY, hold_data = 0. Reset applied mid-stall discards HELD data.
- mem_to_id_bus is valid in the same cycle as mem_to_wb_bus, so ID can forward within that cycle.
- A bubble (rule 2) forces rf_we=0, hi_we=0, lo_we=0 and pc=0 on the following cycle.
- Capture happens on the first frozen edge only. If several stall cycles follow, the output after the first edge equals the value from the load's first MEM cycle.
- If stall[4]==Stop while stall[3]==NoStop, the controller has produced an illegal combination. The stage still applies rule 3.

## Test plan
- Reset: assert rst for 2 cycles with non-zero inputs → all outputs 0; FSM EMPTY.
- Sign-extension check: lb, ex_result=0x1000_0003, rdata=0x80FF_1234 → rf_wdata=0xFFFF_FF80. Same access with lbu → 0x0000_0080.
- Halfword select: lh at addr 0x...2 with rdata 0x80FF_1234 → 0xFFFF_80FF. lhu at addr 0x...0 → 0x0000_1234.
- Hold buffer: lw enters MEM with rdata=0x1234_5678. Next 3 cycles stall[3]=stall[4]=Stop while rdata=0xDEAD_BEEF → rf_wdata stays 0x1234_5678 throughout. Release stall → next instruction's data is used, FSM EMPTY.
- Bubble: stall=6'b001111 for one edge → next cycle mem_to_wb_bus=0 and mem_to_wb1=0.
- HI/LO passthrough: ex_to_mem1={1,0,0xAAAA_0001,0x5555_0002} → next cycle mem_to_wb1 and mem_to_id_2 carry the same value. Non-load ALU op with ex_result=0x7 → rf_wdata=0x7.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the five-stage CPU: EX/MEM register, load extraction with a
// one-entry hold buffer for frozen loads, and the WB / ID forwarding buses.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [78:0] ex_to_mem_bus,
  input  logic [65:0] ex_to_mem1,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [65:0] mem_to_wb1,
  output logic [37:0] mem_to_id_bus,
  output logic [65:0] mem_to_id_2
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HELD  = 1'b1;

  logic [78:0] bus_p1;
  logic [65:0] hilo_p1;
  logic [0:0]  state_p1;
  logic [31:0] hold_data_p1;

  logic        bubble;
  logic        advance;
  logic        unused_stall;

  logic [31:0] pc;
  logic        data_ram_en;
  logic [3:0]  data_ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [2:0]  load_type;

  logic        is_load;
  logic [31:0] raw_data;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;

  function automatic logic [31:0] extract_load(input logic [31:0] raw,
                                               input logic [1:0]  addr,
                                               input logic [2:0]  lt);
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;
    logic [31:0]        res;
    sbyte = raw[8*addr +: 8];
    shalf = addr[1] ? raw[31:16] : raw[15:0];
    case (lt)
      3'b001:  res = 32'(sbyte);
      3'b010:  res = {24'd0, sbyte};
      3'b011:  res = 32'(shalf);
      3'b100:  res = {16'd0, shalf};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign bubble       = (stall[3] == STOP) && (stall[4] == NO_STOP);
  assign advance      = (stall[3] == NO_STOP);
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Stage p1: EX/MEM register; an illegal stall[4]-only freeze still advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_p1  <= '0;
      hilo_p1 <= '0;
    end else if (bubble) begin
      bus_p1  <= '0;
      hilo_p1 <= '0;
    end else if (advance) begin
      bus_p1  <= ex_to_mem_bus;
      hilo_p1 <= ex_to_mem1;
    end
  end

  assign {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr,
          ex_result, load_type} = bus_p1;

  assign is_load = data_ram_en && (data_ram_wen == 4'd0) && sel_rf_res;

  // Hold buffer: the SRAM word is only valid on the first MEM cycle, so a
  // frozen load captures it on the first frozen edge and replays it after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1     <= EMPTY;
      hold_data_p1 <= '0;
    end else if (bubble || advance) begin
      state_p1 <= EMPTY;
    end else if ((state_p1 == EMPTY) && is_load) begin
      state_p1     <= HELD;
      hold_data_p1 <= data_sram_rdata;
    end
  end

  assign raw_data  = (state_p1 == HELD) ? hold_data_p1 : data_sram_rdata;
  assign load_data = extract_load(raw_data, ex_result[1:0], load_type);
  assign rf_wdata  = sel_rf_res ? load_data : ex_result;

  assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
  assign mem_to_id_bus = {rf_we, rf_waddr, rf_wdata};
  assign mem_to_wb1    = hilo_p1;
  assign mem_to_id_2   = hilo_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed loads, stalls, bubbles and resets.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [78:0] ex_to_mem_bus = '0;
  logic [65:0] ex_to_mem1 = '0;
  logic [31:0] data_sram_rdata = '0;
  logic [69:0] mem_to_wb_bus;
  logic [65:0] mem_to_wb1;
  logic [37:0] mem_to_id_bus;
  logic [65:0] mem_to_id_2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [69:0] wb;
    logic [65:0] wb1;
  } exp_t;

  exp_t sb[$];

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_mem1      (ex_to_mem1),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_wb1      (mem_to_wb1),
    .mem_to_id_bus   (mem_to_id_bus),
    .mem_to_id_2     (mem_to_id_2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] mk_bus(input logic [31:0] pc, input logic en,
                                         input logic [3:0] wen, input logic sel,
                                         input logic we, input logic [4:0] waddr,
                                         input logic [31:0] res, input logic [2:0] lt);
    return {pc, en, wen, sel, we, waddr, res, lt};
  endfunction

  function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] wdata);
    return {pc, we, waddr, wdata};
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare once the DUT presents it.
  task automatic step(input string tag, input logic [5:0] st, input logic [78:0] bus,
                      input logic [65:0] e1, input logic [31:0] rd,
                      input logic [69:0] xwb, input logic [65:0] xwb1);
    exp_t e;
    @(negedge clk);
    stall         = st;
    ex_to_mem_bus = bus;
    ex_to_mem1    = e1;
    e.wb  = xwb;
    e.wb1 = xwb1;
    sb.push_back(e);
    @(posedge clk);
    #1 data_sram_rdata = rd;
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 128'd0, 128'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_wb"},   128'(mem_to_wb_bus), 128'(e.wb));
      check({tag, "_wb1"},  128'(mem_to_wb1),    128'(e.wb1));
      check({tag, "_id"},   128'(mem_to_id_bus), 128'(e.wb[37:0]));
      check({tag, "_id2"},  128'(mem_to_id_2),   128'(e.wb1));
    end
  endtask

  localparam logic [65:0] E1 = {1'b1, 1'b0, 32'hAAAA_0001, 32'h5555_0002};
  localparam logic [65:0] E2 = {1'b0, 1'b1, 32'h0BAD_F00D, 32'h1234_0000};
  localparam logic [5:0]  RUN    = 6'b000000;
  localparam logic [5:0]  FREEZE = 6'b011111;
  localparam logic [5:0]  BUBBLE = 6'b001111;
  localparam logic [5:0]  ILLEGAL = 6'b010000;

  initial begin
    logic [78:0] noise;
    noise = mk_bus(32'hFFFF_FFF0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd31, 32'h8765_4321, 3'b001);

    // reset with non-zero inputs
    rst = 1'b1;
    step("rst0", RUN, noise, E1, 32'hFFFF_FFFF, '0, '0);
    step("rst1", RUN, noise, E1, 32'hFFFF_FFFF, '0, '0);
    rst = 1'b0;

    // load extraction
    step("lb3", RUN, mk_bus(32'h100, 1, 0, 1, 1, 5'd3, 32'h1000_0003, 3'b001), E2,
         32'h80FF_1234, mk_wb(32'h100, 1, 5'd3, 32'hFFFF_FF80), E2);
    step("lbu3", RUN, mk_bus(32'h104, 1, 0, 1, 1, 5'd4, 32'h1000_0003, 3'b010), E2,
         32'h80FF_1234, mk_wb(32'h104, 1, 5'd4, 32'h0000_0080), E2);
    step("lh2", RUN, mk_bus(32'h108, 1, 0, 1, 1, 5'd5, 32'h1000_0002, 3'b011), E2,
         32'h80FF_1234, mk_wb(32'h108, 1, 5'd5, 32'hFFFF_80FF), E2);
    step("lhu0", RUN, mk_bus(32'h10C, 1, 0, 1, 1, 5'd6, 32'h1000_0000, 3'b100), E2,
         32'h80FF_1234, mk_wb(32'h10C, 1, 5'd6, 32'h0000_1234), E2);
    step("lb2", RUN, mk_bus(32'h110, 1, 0, 1, 1, 5'd7, 32'h1000_0002, 3'b001), E2,
         32'h80FF_1234, mk_wb(32'h110, 1, 5'd7, 32'hFFFF_FFFF), E2);
    step("lbu1", RUN, mk_bus(32'h114, 1, 0, 1, 1, 5'd8, 32'h1000_0001, 3'b010), E2,
         32'h80FF_1234, mk_wb(32'h114, 1, 5'd8, 32'h0000_0012), E2);
    step("lh3", RUN, mk_bus(32'h118, 1, 0, 1, 1, 5'd9, 32'h1000_0001, 3'b011), E2,
         32'h80FF_1234, mk_wb(32'h118, 1, 5'd9, 32'h0000_1234), E2);
    step("lt7", RUN, mk_bus(32'h11C, 1, 0, 1, 1, 5'd10, 32'h1000_0001, 3'b111), E2,
         32'h80FF_1234, mk_wb(32'h11C, 1, 5'd10, 32'h80FF_1234), E2);

    // ALU result and HI/LO passthrough
    step("alu", RUN, mk_bus(32'h120, 0, 0, 0, 1, 5'd9, 32'h0000_0007, 3'b000), E1,
         32'hDEAD_BEEF, mk_wb(32'h120, 1, 5'd9, 32'h0000_0007), E1);
    step("store", RUN, mk_bus(32'h124, 1, 4'hF, 0, 0, 5'd0, 32'h2000_0010, 3'b000), E1,
         32'hDEAD_BEEF, mk_wb(32'h124, 0, 5'd0, 32'h2000_0010), E1);

    // hold buffer across a three-cycle freeze
    step("lw", RUN, mk_bus(32'h200, 1, 0, 1, 1, 5'd5, 32'h2000_0000, 3'b000), E1,
         32'h1234_5678, mk_wb(32'h200, 1, 5'd5, 32'h1234_5678), E1);
    for (int i = 0; i < 3; i++)
      step("hold", FREEZE, noise, E2, 32'hDEAD_BEEF,
           mk_wb(32'h200, 1, 5'd5, 32'h1234_5678), E1);
    step("release", RUN, mk_bus(32'h204, 1, 0, 1, 1, 5'd6, 32'h2000_0004, 3'b000), E2,
         32'hCAFE_F00D, mk_wb(32'h204, 1, 5'd6, 32'hCAFE_F00D), E2);

    // bubble injection, then illegal stall combination still advances
    step("bubble", BUBBLE, noise, E1, 32'hCAFE_F00D, '0, '0);
    step("illegal", ILLEGAL, mk_bus(32'h208, 0, 0, 0, 1, 5'd11, 32'h0000_00AB, 3'b000), E1,
         32'hCAFE_F00D, mk_wb(32'h208, 1, 5'd11, 32'h0000_00AB), E1);

    // reset applied while a load is held discards the held word
    step("lw2", RUN, mk_bus(32'h300, 1, 0, 1, 1, 5'd12, 32'h3000_0000, 3'b000), E2,
         32'h1111_2222, mk_wb(32'h300, 1, 5'd12, 32'h1111_2222), E2);
    step("hold2", FREEZE, noise, E1, 32'h3333_4444,
         mk_wb(32'h300, 1, 5'd12, 32'h1111_2222), E2);
    rst = 1'b1;
    step("rst_mid", FREEZE, noise, E1, 32'h3333_4444, '0, '0);
    rst = 1'b0;
    step("after_rst", RUN, mk_bus(32'h304, 1, 0, 1, 1, 5'd13, 32'h3000_0004, 3'b000), E1,
         32'h5555_6666, mk_wb(32'h304, 1, 5'd13, 32'h5555_6666), E1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
